// File: rtl/bus_pkg.sv
// Shared bus definitions: default packet geometry, packet type, destination-ID field helpers.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package bus_pkg;

  localparam int BUS_WIDTH = 16;
  localparam int BUS_DEPTH = 8;

  // Destination ID lives in the top ID_BITS of every packet; the FIFO never looks at it.
  localparam int ID_BITS = 4;

  typedef logic [BUS_WIDTH-1:0] pkt_t;

  // Extract the destination ID of a packet (used by the bus and the generator).
  function automatic logic [ID_BITS-1:0] pkt_dest(input pkt_t p);
    return p[BUS_WIDTH-1 -: ID_BITS];
  endfunction

endpackage

// File: rtl/bus_fifo_ptr.sv
// Wrapping pointer register counting 0..MAX, returning to 0 after MAX (no power-of-two assumption).
// Latency: new value visible one clk after inc.
// Backpressure: none; the owner decides when to assert inc.
module bus_fifo_ptr #(
  parameter int MAX = 7,
  parameter int PW  = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(MAX);

  // Advance on inc, explicitly wrapping from LAST back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bus_dev_fifo.sv
// Per-device first-word-fall-through transmit FIFO feeding the shared bus (optional stats: BUS_DEV_FIFO_STATS_EN).
// Latency: a push at edge N shows on D_pop/pndng after edge N; a pop exposes the next entry after the same edge.
// Backpressure: full blocks pushes unless a pop frees a slot that cycle; dropped pushes/empty pops pulse overflow/underflow.
module bus_dev_fifo
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = BUS_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] D_push,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] D_pop,
  output logic             pndng,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
`ifdef BUS_DEV_FIFO_STATS_EN
  ,
  output logic [15:0]      drop_cnt,
  output logic [CW-1:0]    max_count
`endif
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign full   = (count == FULL_CNT);
  assign pndng  = (count != '0);
  assign do_pop  = pop & pndng;
  assign do_push = push & (~full | do_pop);
  assign D_pop  = mem[rd_ptr];

  bus_fifo_ptr #(.MAX(DEPTH - 1), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (do_pop),
    .ptr   (rd_ptr)
  );

  bus_fifo_ptr #(.MAX(DEPTH - 1), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (do_push),
    .ptr   (wr_ptr)
  );

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array; cleared on reset so D_pop reads zero while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= D_push;
    end
  end

  // Occupancy and the per-cycle error pulses (high again on every offending cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= push & ~do_push;
      underflow <= pop & ~pndng;
    end
  end

`ifdef BUS_DEV_FIFO_STATS_EN
  // Saturating dropped-push counter and occupancy high-water mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt  <= '0;
      max_count <= '0;
    end else begin
      if (push && !do_push && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (count_nxt > max_count) begin
        max_count <= count_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_dev_fifo.sv
module tb_bus_dev_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        push8 = 1'b0, pop8 = 1'b0;
  logic [15:0] din8 = '0;
  logic [15:0] dout8;
  logic        full8, pndng8, ovf8, unf8;
  logic [3:0]  count8;

  logic        push5 = 1'b0, pop5 = 1'b0;
  logic [15:0] din5 = '0;
  logic [15:0] dout5;
  logic        full5, pndng5, ovf5, unf5;
  logic [2:0]  count5;

`ifdef BUS_DEV_FIFO_STATS_EN
  logic [15:0] drop8, drop5;
  logic [3:0]  max8;
  logic [2:0]  max5;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_dev_fifo #(.WIDTH(16), .DEPTH(8)) u8 (
    .clk(clk), .reset(reset), .push(push8), .D_push(din8), .full(full8),
    .pop(pop8), .D_pop(dout8), .pndng(pndng8), .count(count8),
    .overflow(ovf8), .underflow(unf8)
`ifdef BUS_DEV_FIFO_STATS_EN
    , .drop_cnt(drop8), .max_count(max8)
`endif
  );

  bus_dev_fifo #(.WIDTH(16), .DEPTH(5)) u5 (
    .clk(clk), .reset(reset), .push(push5), .D_push(din5), .full(full5),
    .pop(pop5), .D_pop(dout5), .pndng(pndng5), .count(count5),
    .overflow(ovf5), .underflow(unf5)
`ifdef BUS_DEV_FIFO_STATS_EN
    , .drop_cnt(drop5), .max_count(max5)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if ({pndng8, full8, ovf8, unf8} !== 4'b0000) begin failures++; $display("FAIL reset_flags8 got=%b want=0000", {pndng8, full8, ovf8, unf8}); end
    checks++; if (count8 !== 4'd0) begin failures++; $display("FAIL reset_count8 got=%0d want=0", count8); end
    checks++; if (dout8 !== 16'h0000) begin failures++; $display("FAIL reset_dpop8 got=%h want=0000", dout8); end
    checks++; if ({pndng5, full5, count5} !== 5'b0) begin failures++; $display("FAIL reset_state5 got=%b want=00000", {pndng5, full5, count5}); end
    reset = 1'b0;
    step();
    checks++; if ({pndng8, full8, count8, dout8} !== 22'b0) begin failures++; $display("FAIL idle8 pndng=%b full=%b count=%0d dpop=%h want all 0", pndng8, full8, count8, dout8); end
  endtask

  task automatic test_fifo_order();
    logic [15:0] exp [3];
    exp[0] = 16'hA001; exp[1] = 16'hA002; exp[2] = 16'hA003;
    push8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din8 = exp[i];
      step();
      checks++; if (count8 !== 4'(i + 1)) begin failures++; $display("FAIL order_count_push%0d got=%0d want=%0d", i, count8, i + 1); end
      checks++; if (dout8 !== 16'hA001 || pndng8 !== 1'b1) begin failures++; $display("FAIL order_head_push%0d dpop=%h pndng=%b want A001/1", i, dout8, pndng8); end
    end
    push8 = 1'b0;
    pop8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout8 !== exp[i]) begin failures++; $display("FAIL order_pop%0d got=%h want=%h", i, dout8, exp[i]); end
      step();
    end
    pop8 = 1'b0;
    checks++; if (count8 !== 4'd0 || pndng8 !== 1'b0) begin failures++; $display("FAIL order_drained count=%0d pndng=%b want 0/0", count8, pndng8); end
    checks++; if (unf8 !== 1'b0) begin failures++; $display("FAIL order_no_underflow got=%b want=0", unf8); end
  endtask

  task automatic test_overflow_and_full_wrap();
    logic [15:0] exp [8];
    push8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din8 = 16'h1000 + 16'(i);
      step();
    end
    checks++; if (full8 !== 1'b1 || count8 !== 4'd8) begin failures++; $display("FAIL fill full=%b count=%0d want 1/8", full8, count8); end
    checks++; if (ovf8 !== 1'b0) begin failures++; $display("FAIL fill_no_overflow got=%b want=0", ovf8); end
    din8 = 16'hDEAD;
    step();
    checks++; if (ovf8 !== 1'b1 || count8 !== 4'd8) begin failures++; $display("FAIL overflow_pulse ovf=%b count=%0d want 1/8", ovf8, count8); end
    push8 = 1'b0;
    step();
    checks++; if (ovf8 !== 1'b0) begin failures++; $display("FAIL overflow_one_cycle got=%b want=0", ovf8); end
`ifdef BUS_DEV_FIFO_STATS_EN
    checks++; if (drop8 !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d want=1", drop8); end
    checks++; if (max8 !== 4'd8) begin failures++; $display("FAIL max_count got=%0d want=8", max8); end
`endif
    // Full with push and pop together for four cycles.
    push8 = 1'b1;
    pop8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din8 = 16'h2000 + 16'(i);
      checks++; if (dout8 !== 16'h1000 + 16'(i)) begin failures++; $display("FAIL fullpp_head%0d got=%h want=%h", i, dout8, 16'h1000 + 16'(i)); end
      step();
      checks++; if (count8 !== 4'd8 || full8 !== 1'b1 || ovf8 !== 1'b0) begin failures++; $display("FAIL fullpp_state%0d count=%0d full=%b ovf=%b want 8/1/0", i, count8, full8, ovf8); end
    end
    push8 = 1'b0;
    for (int i = 0; i < 4; i++) exp[i] = 16'h1004 + 16'(i);
    for (int i = 0; i < 4; i++) exp[i + 4] = 16'h2000 + 16'(i);
    for (int i = 0; i < 8; i++) begin
      checks++; if (dout8 !== exp[i]) begin failures++; $display("FAIL drain%0d got=%h want=%h", i, dout8, exp[i]); end
      step();
    end
    pop8 = 1'b0;
    checks++; if (count8 !== 4'd0 || pndng8 !== 1'b0 || unf8 !== 1'b0) begin failures++; $display("FAIL drain_end count=%0d pndng=%b unf=%b want 0/0/0", count8, pndng8, unf8); end
  endtask

  task automatic test_empty_push_pop();
    push8 = 1'b1;
    pop8 = 1'b1;
    din8 = 16'h0055;
    step();
    push8 = 1'b0;
    pop8 = 1'b0;
    checks++; if (unf8 !== 1'b1) begin failures++; $display("FAIL empty_pp_underflow got=%b want=1", unf8); end
    checks++; if (count8 !== 4'd1 || dout8 !== 16'h0055 || pndng8 !== 1'b1) begin failures++; $display("FAIL empty_pp_state count=%0d dpop=%h pndng=%b want 1/0055/1", count8, dout8, pndng8); end
    step();
    checks++; if (unf8 !== 1'b0 || dout8 !== 16'h0055) begin failures++; $display("FAIL empty_pp_hold unf=%b dpop=%h want 0/0055", unf8, dout8); end
    pop8 = 1'b1;
    step();
    checks++; if (count8 !== 4'd0 || unf8 !== 1'b0) begin failures++; $display("FAIL empty_pp_drain count=%0d unf=%b want 0/0", count8, unf8); end
    // Two consecutive pops on an empty FIFO keep underflow high for both cycles.
    step();
    checks++; if (unf8 !== 1'b1 || count8 !== 4'd0) begin failures++; $display("FAIL empty_pop1 unf=%b count=%0d want 1/0", unf8, count8); end
    step();
    pop8 = 1'b0;
    checks++; if (unf8 !== 1'b1) begin failures++; $display("FAIL empty_pop2 unf=%b want=1", unf8); end
    step();
    checks++; if (unf8 !== 1'b0 || count8 !== 4'd0) begin failures++; $display("FAIL empty_pop_end unf=%b count=%0d want 0/0", unf8, count8); end
  endtask

  task automatic test_back_to_back();
    // DEPTH=5: prime with 3, stream 17 push+pop cycles, drain 3; 20 words through, pointers wrap 4->0 repeatedly.
    push5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din5 = 16'h3000 + 16'(i);
      step();
    end
    pop5 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din5 = 16'h3003 + 16'(i);
      checks++; if (dout5 !== 16'h3000 + 16'(i)) begin failures++; $display("FAIL d5_stream%0d got=%h want=%h", i, dout5, 16'h3000 + 16'(i)); end
      step();
      checks++; if (count5 !== 3'd3) begin failures++; $display("FAIL d5_count%0d got=%0d want=3", i, count5); end
    end
    push5 = 1'b0;
    for (int i = 17; i < 20; i++) begin
      checks++; if (dout5 !== 16'h3000 + 16'(i)) begin failures++; $display("FAIL d5_drain%0d got=%h want=%h", i, dout5, 16'h3000 + 16'(i)); end
      step();
    end
    pop5 = 1'b0;
    checks++; if (count5 !== 3'd0 || pndng5 !== 1'b0) begin failures++; $display("FAIL d5_empty count=%0d pndng=%b want 0/0", count5, pndng5); end
    // Fill to 5 to see full on a non-power-of-two depth.
    push5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din5 = 16'h4000 + 16'(i);
      step();
    end
    push5 = 1'b0;
    checks++; if (full5 !== 1'b1 || count5 !== 3'd5 || dout5 !== 16'h4000) begin failures++; $display("FAIL d5_full full=%b count=%0d dpop=%h want 1/5/4000", full5, count5, dout5); end
    pop5 = 1'b1;
    step();
    step();
    pop5 = 1'b0;
    checks++; if (count5 !== 3'd3 || dout5 !== 16'h4002) begin failures++; $display("FAIL d5_pre_reset count=%0d dpop=%h want 3/4002", count5, dout5); end
    // Reset asserted between clock edges must clear immediately.
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count5 !== 3'd0 || pndng5 !== 1'b0 || dout5 !== 16'h0000) begin failures++; $display("FAIL d5_async_reset count=%0d pndng=%b dpop=%h want 0/0/0000", count5, pndng5, dout5); end
    step();
    reset = 1'b0;
    step();
    checks++; if (count5 !== 3'd0 || full5 !== 1'b0) begin failures++; $display("FAIL d5_after_reset count=%0d full=%b want 0/0", count5, full5); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow_and_full_wrap();
    test_empty_push_pop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_dev_fifo.md
# bus_dev_fifo

Per-device transmit FIFO that sits directly upstream of the shared bus. A device agent pushes WIDTH-bit packets, and the bus pops them through the pndng/pop/D_pop handshake. One instance exists per device, so DISPOSITIVOS instances are generated beside the bus. The FIFO is first-word-fall-through: the head packet is always visible on D_pop while pndng is high.

## Interface
- WIDTH, 16, packet width in bits (destination ID plus payload; the FIFO does not interpret it)
- DEPTH, 8, number of entries; any value ≥2 (power of two not required)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- push  in  1  device writes D_push this cycle
- D_push  in  WIDTH  packet to enqueue
- full  out  1  count == DEPTH
- pop  in  1  bus consumes the head this cycle
- D_pop  out  WIDTH  head packet, valid when pndng=1
- pndng  out  1  count != 0
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  one-cycle pulse: a push was dropped
- underflow  out  1  one-cycle pulse: a pop arrived while empty

## Operation
- Storage: DEPTH×WIDTH register array, plus rd_ptr/wr_ptr in 0..DEPTH-1. Each pointer wraps from DEPTH-1 to 0 explicitly, with no modulo-2^n assumption.
- Accept rules, evaluated on the same clk edge:
  - do_pop = pop & pndng
  - do_push = push & (~full | do_pop)
- On do_push: mem[wr_ptr] ← D_push and wr_ptr advances. On do_pop: rd_ptr advances.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Boundary cases:
  - Full with push and pop together: both are accepted, count stays DEPTH, full stays 1.
  - Empty with push and pop together: the push is accepted and the pop is ignored (no bypass). underflow pulses and count becomes 1.
  - Full with push only: the push is dropped, contents are unchanged, and overflow=1 for the next cycle.
  - Empty with pop only: nothing changes and underflow=1 for the next cycle.
- D_pop = mem[rd_ptr]. It is combinational from registers and is held stable while pndng=1 and no pop occurs.
- Reset mid-operation: all contents are discarded immediately, with no drain.

## Timing
- Reset values (asynchronous, take effect while reset is high):
  - rd_ptr = wr_ptr = 0, count = 0
  - pndng = 0, full = 0, overflow = 0, underflow = 0
  - all mem entries = 0, so D_pop = 0
- Write-to-read latency: a packet pushed at edge N drives pndng=1 and D_pop after edge N (usable by the bus at edge N+1).
- A pop at edge N makes the next entry visible on D_pop after edge N.
- full, pndng and count are registered-derived and update after the accepting edge.
- overflow and underflow are registered pulses, exactly one cycle wide per offending cycle. They are level-high across consecutive offending cycles.
- Throughput is one push and one pop per cycle.

## Configuration
- Macro: BUS_DEV_FIFO_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0], which increments on every dropped push and saturates at 16'hFFFF.
  - Adds output max_count [$clog2(DEPTH+1)-1:0], a high-water mark of count.
  - Both outputs reset to 0.
- Undefined:
  - Both ports and their logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package bus_pkg holds:
  - default WIDTH/DEPTH constants
  - typedef pkt_t (logic [WIDTH-1:0])
  - localparam ID_BITS, with the destination ID occupying the MSBs, used by the bus and generator
- Sub-module bus_fifo_ptr(MAX) is the wrapping pointer register with an inc input. It is instantiated twice (rd/wr).

## Test plan
- Reset then idle: pndng=0, full=0, count=0, D_pop=0.
- Push 16'hA001, 16'hA002, 16'hA003 on consecutive cycles, then pop three times:
  - D_pop sequence A001, A002, A003
  - count returns to 0 and pndng drops after the third pop
- DEPTH=8: push 8 words so full=1. A 9th push of 16'hDEAD is dropped and overflow pulses once. Popping 8 words never shows DEAD. With STATS_EN, drop_cnt=1.
- Full FIFO with push=pop=1 for 4 cycles: count stays 8, full stays 1, and order is preserved across the rd/wr wrap.
- Empty FIFO with push=pop=1 of 16'h0055: underflow pulses, count=1, D_pop=0055.
- DEPTH=5 (non-power-of-two): push/pop 20 words. Order is preserved and the pointers wrap 4→0. Asserting reset mid-stream with count=3 clears to count=0 and pndng=0 immediately.
